// File: rtl/ps2_host_transmitter_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states, timing defaults,
// well-known command bytes and small helper functions.
package ps2_host_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_DATA      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } ps2_tx_state_e;

    localparam int unsigned DEF_INHIBIT_CYCLES = 32'd5000;
    localparam int unsigned DEF_START_TIMEOUT  = 32'd750000;
    localparam int unsigned DEF_XFER_TIMEOUT   = 32'd100000;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // Released open-drain lines read back high
    localparam logic LINE_IDLE = 1'b1;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 pad plus falling-edge detect on the synchronised level.
module ps2_line_sync
    import ps2_host_transmitter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_sync,
    output logic line_fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain plus one cycle of history for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= LINE_IDLE;
            sync_r <= LINE_IDLE;
            prev_r <= LINE_IDLE;
        end else begin
            meta_r <= line_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign line_sync = sync_r;
    assign line_fall = prev_r & ~sync_r;

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command sender: inhibit, request-to-send, 10 frame bits on device clock
// falling edges, ACK check, then a one-cycle done or error pulse. Outputs are all registered.
module ps2_host_transmitter
    import ps2_host_transmitter_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int unsigned XFER_TIMEOUT   = DEF_XFER_TIMEOUT
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_strb,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    // Wide enough for whichever limit is largest, so the transfer timer can share the width
    localparam int unsigned TMR_W =
        $clog2(max_u(max_u(INHIBIT_CYCLES, START_TIMEOUT), XFER_TIMEOUT) + 32'd1);
    localparam logic [TMR_W-1:0] INH_LAST   = TMR_W'(INHIBIT_CYCLES - 32'd1);
    localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TIMEOUT);
    localparam logic [TMR_W-1:0] XFER_LAST  = TMR_W'(XFER_TIMEOUT);

    ps2_tx_state_e    state_r, state_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic [TMR_W-1:0] xfer_r, xfer_s;
    logic [3:0]       bit_cnt_r, bit_cnt_s;
    logic [7:0]       data_r, data_s;
    logic             par_r, par_s;
    logic             clk_oe_r, clk_oe_s;
    logic             data_oe_r, data_oe_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             error_r, error_s;
    logic             terminal_s;
    logic [9:0]       frame_s;
    logic             clk_sync_s, clk_fall_s;
    logic             data_sync_s, data_fall_unused_s;

    ps2_line_sync u_clk_sync (
        .clk       (clk),
        .rst       (rst),
        .line_in   (ps2_clk_in),
        .line_sync (clk_sync_s),
        .line_fall (clk_fall_s)
    );

    ps2_line_sync u_data_sync (
        .clk       (clk),
        .rst       (rst),
        .line_in   (ps2_data_in),
        .line_sync (data_sync_s),
        .line_fall (data_fall_unused_s)
    );

    // Frame bits in send order: data LSB first, odd parity, stop
    assign frame_s = {1'b1, par_r, data_r};

    // Next-state and next-output logic; pulses and line releases derive from the next state
    always_comb begin
        state_s   = state_r;
        data_s    = data_r;
        par_s     = par_r;
        bit_cnt_s = bit_cnt_r;
        clk_oe_s  = 1'b0;
        data_oe_s = data_oe_r;
        busy_s    = busy_r;
        case (state_r)
            ST_IDLE: begin
                data_oe_s = 1'b0;
                if (tx_strb) begin
                    data_s    = tx_data;
                    par_s     = odd_parity(tx_data);
                    bit_cnt_s = 4'd0;
                    busy_s    = 1'b1;
                    clk_oe_s  = 1'b1;
                    state_s   = ST_INHIBIT;
                end else begin
                    busy_s    = 1'b0;
                end
            end
            ST_INHIBIT: begin
                if (timer_r == INH_LAST) begin
                    data_oe_s = 1'b1;
                    state_s   = ST_REQ;
                end else begin
                    clk_oe_s  = 1'b1;
                end
            end
            ST_REQ: begin
                if (clk_fall_s) begin
                    data_oe_s = ~frame_s[bit_cnt_r];
                    bit_cnt_s = bit_cnt_r + 4'd1;
                    state_s   = ST_DATA;
                end else if (timer_r == START_LAST) begin
                    state_s   = ST_ERROR;
                end else begin
                    data_oe_s = 1'b1;
                end
            end
            ST_DATA: begin
                if (xfer_r == XFER_LAST) begin
                    state_s   = ST_ERROR;
                end else if (clk_fall_s) begin
                    data_oe_s = ~frame_s[bit_cnt_r];
                    bit_cnt_s = bit_cnt_r + 4'd1;
                    state_s   = (bit_cnt_r == 4'd9) ? ST_ACK : ST_DATA;
                end else begin
                    state_s   = ST_DATA;
                end
            end
            ST_ACK: begin
                if (xfer_r == XFER_LAST) begin
                    state_s = ST_ERROR;
                end else if (clk_fall_s) begin
                    state_s = data_sync_s ? ST_ERROR : ST_WAIT_IDLE;
                end else begin
                    state_s = ST_ACK;
                end
            end
            ST_WAIT_IDLE: begin
                if (xfer_r == XFER_LAST) begin
                    state_s = ST_ERROR;
                end else if (clk_sync_s && data_sync_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT_IDLE;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            ST_ERROR: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase

        done_s     = (state_s == ST_DONE);
        error_s    = (state_s == ST_ERROR);
        terminal_s = done_s | error_s;
        busy_s     = busy_s & ~terminal_s;
        clk_oe_s   = clk_oe_s & ~terminal_s;
        data_oe_s  = data_oe_s & ~terminal_s;

        // One shared state timer restarts on every state change; the transfer timer runs from the first edge
        timer_s = ((state_s != state_r) || (state_r == ST_IDLE)) ? {TMR_W{1'b0}} : timer_r + TMR_W'(1);
        xfer_s  = ((state_r == ST_DATA) || (state_r == ST_ACK) || (state_r == ST_WAIT_IDLE))
                  ? xfer_r + TMR_W'(1) : {TMR_W{1'b0}};
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            timer_r   <= {TMR_W{1'b0}};
            xfer_r    <= {TMR_W{1'b0}};
            bit_cnt_r <= 4'd0;
            data_r    <= 8'h00;
            par_r     <= 1'b0;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            xfer_r    <= xfer_s;
            bit_cnt_r <= bit_cnt_s;
            data_r    <= data_s;
            par_r     <= par_s;
            clk_oe_r  <= clk_oe_s;
            data_oe_r <= data_oe_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            error_r   <= error_s;
        end
    end

    assign tx_busy     = busy_r;
    assign tx_done     = done_r;
    assign tx_error    = error_r;
    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Self-checking bench: a behavioural PS/2 keyboard clocks frames out of the transmitter and
// compares captured bits, pulses and timing with values computed from the protocol rules.
module tb_ps2_host_transmitter;
    import ps2_host_transmitter_pkg::*;

    localparam int INH = 50;
    localparam int STO = 2000;
    localparam int XTO = 20000;
    localparam int HP = 30;
    localparam int BOUND = 30000;
    localparam int DEV_ACK = 0;
    localparam int DEV_NACK = 1;
    localparam int DEV_SILENT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_strb = 1'b0;
    logic       tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int cyc = 0, req_cyc = 0, err_cyc = 0, inh_run = 0, inh_len = 0;
    logic pulse_busy = 1'b0, pulse_clk_oe = 1'b0, pulse_data_oe = 1'b0, prev_data_oe = 1'b0;

    // Wired-AND open-drain lines shared by host and device
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_transmitter #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (STO),
        .XFER_TIMEOUT   (XTO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_strb     (tx_strb),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    // Pulse counting and line-drive timing, observed on the inactive edge
    always @(negedge clk) begin
        cyc          <= cyc + 1;
        prev_data_oe <= ps2_data_oe;
        if (ps2_data_oe && !prev_data_oe) req_cyc <= cyc;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
        if (tx_done || tx_error) begin
            pulse_busy    <= tx_busy;
            pulse_clk_oe  <= ps2_clk_oe;
            pulse_data_oe <= ps2_data_oe;
        end
        if (ps2_clk_oe) inh_run <= inh_run + 1;
        else if (inh_run != 0) begin
            inh_len <= inh_run;
            inh_run <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference frame: 8 data bits LSB first, then the bit that makes the total count of ones odd, then stop
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        logic p;
        p = (($countones(b) % 2) == 0);
        return {1'b1, p, b};
    endfunction

    task automatic device_frame(input int mode, input bit do_abort, output logic [9:0] got, output bit seen);
        int t;
        got = 10'h000;
        seen = 1'b0;
        t = 0;
        while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && t < BOUND) begin
            tick(1);
            t++;
        end
        if (t < BOUND) begin
            seen = 1'b1;
            if (mode != DEV_SILENT) begin
                tick(HP);
                for (int i = 0; i < 10; i++) begin
                    if (do_abort && i == 4) break;
                    dev_clk_low = 1'b1;
                    tick(HP);
                    dev_clk_low = 1'b0;
                    got[i] = ps2_data_in;
                    tick(HP);
                end
                if (do_abort) begin
                    rst = 1'b0;
                    #1;
                    check_eq("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
                    check_eq("abort_data_oe", 32'(ps2_data_oe), 32'd0);
                    check_eq("abort_busy", 32'(tx_busy), 32'd0);
                    tick(2);
                    rst = 1'b1;
                end else begin
                    dev_data_low = (mode == DEV_ACK);
                    tick(HP);
                    dev_clk_low = 1'b1;
                    tick(HP);
                    dev_clk_low = 1'b0;
                    tick(HP);
                    dev_data_low = 1'b0;
                end
            end
        end
    endtask

    task automatic send_frame(input string tag, input logic [7:0] b, input int mode,
                              input bit inject, input bit do_abort);
        logic [9:0] got;
        bit seen;
        int d0, e0, t;
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data = b;
        tx_strb = 1'b1;
        tick(1);
        tx_strb = 1'b0;
        tx_data = ~b;
        check_eq({tag, "_busy"}, 32'(tx_busy), 32'd1);
        fork
            device_frame(mode, do_abort, got, seen);
            begin
                if (inject) begin
                    tick(100);
                    tx_data = 8'h55;
                    tx_strb = 1'b1;
                    tick(1);
                    tx_strb = 1'b0;
                end
            end
        join
        check_eq({tag, "_rts"}, 32'(seen), 32'd1);
        if (do_abort) begin
            tick(50);
            check_eq({tag, "_busy_after"}, 32'(tx_busy), 32'd0);
            check_eq({tag, "_oe_after"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
            check_eq({tag, "_no_pulse"}, 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        end else begin
            t = 0;
            while (done_cnt == d0 && err_cnt == e0 && t < BOUND) begin
                tick(1);
                t++;
            end
            check_eq({tag, "_timeout"}, 32'(t < BOUND), 32'd1);
            tick(5);
            check_eq({tag, "_inhibit_len"}, 32'(inh_len), 32'(INH));
            check_eq({tag, "_pulse_busy"}, 32'(pulse_busy), 32'd0);
            if (mode != DEV_SILENT) check_eq({tag, "_bits"}, 32'(got), 32'(ref_frame(b)));
            if (mode == DEV_ACK) begin
                check_eq({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
                check_eq({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
            end else begin
                check_eq({tag, "_done"}, 32'(done_cnt - d0), 32'd0);
                check_eq({tag, "_err"}, 32'(err_cnt - e0), 32'd1);
                check_eq({tag, "_err_oe"}, 32'({pulse_clk_oe, pulse_data_oe}), 32'd0);
            end
            if (mode == DEV_SILENT) check_eq({tag, "_start_to"}, 32'(err_cyc - req_cyc), 32'(STO + 1));
        end
    endtask

    initial begin
        logic [7:0] b;
        #1 rst = 1'b0;
        tick(4);
        check_eq("rst_busy", 32'(tx_busy), 32'd0);
        check_eq("rst_done", 32'(tx_done), 32'd0);
        check_eq("rst_error", 32'(tx_error), 32'd0);
        check_eq("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check_eq("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        rst = 1'b1;
        tick(4);

        send_frame("leds", CMD_SET_LEDS, DEV_ACK, 1'b0, 1'b0);
        send_frame("enable", CMD_ENABLE, DEV_ACK, 1'b0, 1'b0);
        send_frame("zero", 8'h00, DEV_ACK, 1'b0, 1'b0);
        send_frame("nack", CMD_SET_LEDS, DEV_NACK, 1'b0, 1'b0);
        send_frame("silent", 8'($urandom_range(0, 255)), DEV_SILENT, 1'b0, 1'b0);
        send_frame("inject", CMD_SET_LEDS, DEV_ACK, 1'b1, 1'b0);
        send_frame("abort", CMD_ENABLE, DEV_ACK, 1'b0, 1'b1);
        send_frame("post_abort", CMD_RESET, DEV_ACK, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom_range(0, 255));
            send_frame($sformatf("rand%0d", k), b, (k == 3) ? DEV_NACK : DEV_ACK, 1'b0, 1'b0);
        end

        check_eq("never_both", 32'(both_cnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
